// File: rtl/i2s_pkg.sv
// Shared I2S definitions: FSM states, channel encoding, default word width.
// Used by both the receive and transmit sides.
package i2s_pkg;

    localparam int AUDIO_DW_DEF = 32;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_deser.sv
// Per-slot MSB-first deserializer with saturating bit and length counters.
// The *_nxt outputs already include the bit currently on i_din.
module i2s_rx_deser
    import i2s_pkg::*;
#(
    parameter int DW = AUDIO_DW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_bit_en,
    input  logic          i_din,
    output logic [DW-1:0] o_word_nxt,
    output logic [DW-1:0] o_len_nxt
);

    localparam int CW = $clog2(DW + 1);
    localparam logic [DW-1:0] TOP = {1'b1, {(DW-1){1'b0}}};

    logic [DW-1:0] r_word;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_len;

    logic [DW-1:0] w_word_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [DW-1:0] w_len_nxt;

    // Shifting TOP by DW or more yields zero, so excess bits drop out.
    always_comb begin
        w_word_nxt = r_word | (i_din ? (TOP >> r_cnt) : '0);
        w_cnt_nxt  = (r_cnt == CW'(DW)) ? r_cnt : r_cnt + 1'b1;
        w_len_nxt  = (&r_len) ? r_len : r_len + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_word <= '0;
            r_cnt  <= '0;
            r_len  <= '0;
        end else if (i_bit_en) begin
            r_word <= w_word_nxt;
            r_cnt  <= w_cnt_nxt;
            r_len  <= w_len_nxt;
        end
    end

    assign o_word_nxt = w_word_nxt;
    assign o_len_nxt  = w_len_nxt;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: word-select edge detection, slot FSM and output registers.
// Presents each left/right pair with a one-cycle valid strobe.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int AUDIO_DW = AUDIO_DW_DEF
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic                lrclk,
    input  logic                sdata,
    output logic [AUDIO_DW-1:0] left_chan,
    output logic [AUDIO_DW-1:0] right_chan,
    output logic                valid,
    output logic [AUDIO_DW-1:0] slot_len,
    output logic                len_err
);

    state_t              r_state;
    logic                r_ws;
    logic [AUDIO_DW-1:0] r_hold;
    logic [AUDIO_DW-1:0] r_left_len;
    logic [AUDIO_DW-1:0] r_left;
    logic [AUDIO_DW-1:0] r_right;
    logic [AUDIO_DW-1:0] r_slot_len;
    logic                r_valid;
    logic                r_len_err;

    logic                w_trans;
    logic                w_fall;
    logic                w_rise;
    logic                w_clear;
    logic                w_bit_en;
    logic [AUDIO_DW-1:0] w_word_nxt;
    logic [AUDIO_DW-1:0] w_len_nxt;

    assign w_trans  = (lrclk != r_ws);
    assign w_fall   = w_trans && (lrclk == CH_LEFT);
    assign w_rise   = w_trans && (lrclk == CH_RIGHT);
    assign w_bit_en = (r_state != HUNT);

    // Slot start: the edge after a transition begins a fresh word.
    assign w_clear  = (r_state == HUNT)
                   || ((r_state == LEFT)  && w_rise)
                   || ((r_state == RIGHT) && w_fall);

    i2s_rx_deser #(
        .DW         (AUDIO_DW)
    ) u_deser (
        .i_clk      (sclk),
        .i_rst      (rst),
        .i_clear    (w_clear),
        .i_bit_en   (w_bit_en),
        .i_din      (sdata),
        .o_word_nxt (w_word_nxt),
        .o_len_nxt  (w_len_nxt)
    );

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state    <= HUNT;
            r_ws       <= 1'b0;
            r_hold     <= '0;
            r_left_len <= '0;
            r_left     <= '0;
            r_right    <= '0;
            r_slot_len <= '0;
            r_valid    <= 1'b0;
            r_len_err  <= 1'b0;
        end else begin
            r_ws    <= lrclk;
            r_valid <= 1'b0;
            unique case (r_state)
                HUNT: begin
                    if (w_fall) r_state <= LEFT;
                end
                LEFT: begin
                    if (w_rise) begin
                        r_hold     <= w_word_nxt;
                        r_left_len <= w_len_nxt;
                        r_state    <= RIGHT;
                    end
                end
                RIGHT: begin
                    if (w_fall) begin
                        r_left     <= r_hold;
                        r_right    <= w_word_nxt;
                        r_slot_len <= w_len_nxt;
                        r_valid    <= 1'b1;
                        if (w_len_nxt != r_left_len) r_len_err <= 1'b1;
                        r_state    <= LEFT;
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end

    assign left_chan  = r_left;
    assign right_chan = r_right;
    assign slot_len   = r_slot_len;
    assign valid      = r_valid;
    assign len_err    = r_len_err;

endmodule

// File: tb/tb_i2s_rx.sv
// Randomized scoreboard bench for i2s_rx: frames are built as slot bit lists,
// expected pairs are queued per frame and checked whenever valid strobes.
module tb_i2s_rx;

    localparam int DW = 32;

    logic          sclk = 1'b0;
    logic          rst = 1'b1;
    logic          lrclk = 1'b0;
    logic          sdata = 1'b0;
    logic [DW-1:0] left_chan;
    logic [DW-1:0] right_chan;
    logic          valid;
    logic [DW-1:0] slot_len;
    logic          len_err;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic [DW-1:0] len;
        logic          err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    bit   q_ch[$];
    bit   q_sd[$];
    bit   q_rst[$];
    bit   m_err = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    i2s_rx #(
        .AUDIO_DW   (DW)
    ) dut (
        .sclk       (sclk),
        .rst        (rst),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .left_chan  (left_chan),
        .right_chan (right_chan),
        .valid      (valid),
        .slot_len   (slot_len),
        .len_err    (len_err)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Word as seen MSB-first in a slot of n bits, left-justified in DW bits.
    function automatic logic [DW-1:0] align(input logic [63:0] w, input int n);
        if (n >= DW) return DW'(w >> (n - DW));
        return DW'(w << (DW - n));
    endfunction

    function automatic logic [63:0] rnd(input int n);
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        if (n < 64) v &= (64'd1 << n) - 64'd1;
        return v;
    endfunction

    task automatic add_slot(input bit ch, input logic [63:0] w, input int n);
        for (int k = 0; k < n; k++) begin
            q_ch.push_back(ch);
            q_sd.push_back(w[n-1-k]);
            q_rst.push_back(1'b0);
        end
    endtask

    task automatic add_frame(input logic [63:0] lw, input logic [63:0] rw,
                             input int nl, input int nr);
        exp_t x;
        add_slot(1'b0, lw, nl);
        add_slot(1'b1, rw, nr);
        m_err = m_err | (nl != nr);
        x.l   = align(lw, nl);
        x.r   = align(rw, nr);
        x.len = DW'(nr);
        x.err = m_err;
        sb.push_back(x);
    endtask

    always @(posedge sclk) begin
        #1;
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got 1 expected 0");
            end else begin
                e = sb.pop_front();
                chk("left_chan", 64'(left_chan), 64'(e.l));
                chk("right_chan", 64'(right_chan), 64'(e.r));
                chk("slot_len", 64'(slot_len), 64'(e.len));
                chk("len_err", 64'(len_err), 64'(e.err));
            end
        end
    end

    initial begin
        int n;
        int sz;
        rst   = 1'b1;
        lrclk = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        chk("rst_left", 64'(left_chan), 64'd0);
        chk("rst_right", 64'(right_chan), 64'd0);
        chk("rst_len", 64'(slot_len), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_err", 64'(len_err), 64'd0);

        // Reset released mid-left-slot: this partial frame is discarded.
        add_slot(1'b0, rnd(7), 7);
        add_slot(1'b1, rnd(32), 32);

        repeat (3) add_frame(64'h12345678, 64'h9ABCDEF0, 32, 32);
        repeat (2) add_frame(64'hABCDEF, 64'h123456, 24, 24);
        repeat (2) add_frame(64'hFFFFFFFF00, 64'h00000001FF, 40, 40);
        add_frame(64'h1, 64'h0, 1, 1);
        add_frame(64'h0, 64'h1, 1, 1);
        for (int i = 0; i < 10; i++) begin
            n = $urandom_range(1, 40);
            add_frame(rnd(n), rnd(n), n, n);
        end

        add_frame(rnd(32), rnd(31), 32, 31);
        repeat (2) add_frame(rnd(32), rnd(32), 32, 32);

        // Frame interrupted by reset during its right slot: never presented.
        add_slot(1'b0, rnd(32), 32);
        add_slot(1'b1, rnd(32), 32);
        sz = q_rst.size();
        q_rst[sz - 20] = 1'b1;
        m_err = 1'b0;

        for (int i = 0; i < 3; i++) add_frame(rnd(32), rnd(32), 32, 32);
        n = $urandom_range(8, 28);
        add_frame(rnd(n), rnd(n), n, n);
        add_slot(1'b0, rnd(5), 5);

        for (int j = 0; j < q_ch.size(); j++) begin
            @(negedge sclk);
            lrclk = (j + 1 < q_ch.size()) ? q_ch[j+1] : q_ch[j];
            sdata = q_sd[j];
            rst   = q_rst[j];
            if (q_rst[j]) begin
                @(posedge sclk);
                #1;
                chk("mid_rst_left", 64'(left_chan), 64'd0);
                chk("mid_rst_right", 64'(right_chan), 64'd0);
                chk("mid_rst_len", 64'(slot_len), 64'd0);
                chk("mid_rst_valid", 64'(valid), 64'd0);
                chk("mid_rst_err", 64'(len_err), 64'd0);
            end
        end

        @(negedge sclk);
        rst   = 1'b0;
        sdata = 1'b0;
        repeat (100) @(posedge sclk);
        #2;
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
